// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential IEEE-754 single divider (restoring, RNE, FTZ); FDIV_SEQ_EARLY_SPECIAL_EN sends zero/inf cases straight to DONE
module fdiv_seq #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [31:0] res,
  output logic        valid_out,
  input  logic        ready_out
);
`ifdef FDIV_SEQ_EARLY_SPECIAL_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] xr, yr, rounded;
  logic [24:0] rem, bm, diff;
  logic [25:0] q;
  logic [CW-1:0] cnt;
  logic [32:0] sp_in, sp_reg;
  logic [22:0] m, f;
  logic signed [9:0] e0, e1;
  logic acc, ge, g, st, c, s;
  function automatic logic [32:0] special(input logic [31:0] a, input logic [31:0] b);
    logic sg;
    sg = a[31] ^ b[31];
    return a[30:23] == 8'h0 ? {1'b1, sg, 31'b0}
         : (b[30:23] == 8'h0 || a[30:0] == 31'h7F80_0000) ? {1'b1, sg, 8'hFF, 23'b0}
         : 33'b0;
  endfunction
  assign ready_in  = state == IDLE;
  assign valid_out = state == DONE;
  assign acc       = valid_in & ready_in;
  assign bm        = {2'b01, yr[22:0]};
  assign sp_in     = special(x, y);
  assign sp_reg    = special(xr, yr);
  // one restoring step, then normalise and round the finished quotient
  always_comb begin
    ge = rem >= bm;
    diff = ge ? rem - bm : rem;
    s = xr[31] ^ yr[31];
    m = q[25] ? q[24:2] : q[23:1];
    g = q[25] ? q[1] : q[0];
    st = (q[25] & q[0]) | (rem != 25'd0);
    {c, f} = {1'b0, m} + {23'b0, g & (st | m[0])};
    e0 = 10'(xr[30:23]) - 10'(yr[30:23]) + (q[25] ? 10'sd127 : 10'sd126);
    e1 = e0 + {9'b0, c};
    rounded = e1 >= 10'sd255 ? {s, 8'hFF, 23'b0} : e1 <= 10'sd0 ? {s, 31'b0} : {s, e1[7:0], f};
  end
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  // next-state sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = valid_in ? ((EARLY && sp_in[32]) ? DONE : DIV) : IDLE;
      DIV:     state_nx = cnt == CW'(ITER - 1) ? ROUND : DIV;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = ready_out ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // operand capture, quotient bit generation and result register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      xr  <= '0;
      yr  <= '0;
      rem <= '0;
      q   <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      if (acc) begin
        xr  <= x;
        yr  <= y;
        rem <= {2'b01, x[22:0]};
        q   <= '0;
        cnt <= '0;
      end else if (state == DIV) begin
        rem <= diff << 1;
        q   <= {q[24:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state == ROUND) res <= sp_reg[32] ? sp_reg[31:0] : rounded;
      if (acc && EARLY && sp_in[32]) res <= sp_in[31:0];
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed checks of fdiv_seq against an exact-rational division model
module tb_fdiv_seq;
`ifdef FDIV_SEQ_EARLY_SPECIAL_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 28;
`endif
  logic clk = 1'b0, rstn = 1'b0, valid_in = 1'b0, ready_out = 1'b1;
  logic [31:0] x = '0, y = '0;
  logic ready_in, valid_out;
  logic [31:0] res;
  int checks = 0, failures = 0;
  logic pending = 1'b0;
  logic [31:0] exp_res = '0;

  fdiv_seq dut (
    .clk(clk), .rstn(rstn), .x(x), .y(y), .valid_in(valid_in), .ready_in(ready_in),
    .res(res), .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // exact quotient of the significands scaled by 2^38, rounded to nearest-even with the true remainder
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned ma, mb, n, r, mant, low, half;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0) return {s, 31'b0};
    if (eb == 0 || (ea == 255 && a[22:0] == 23'b0)) return {s, 8'hFF, 23'b0};
    ma = 64'h80_0000 | 64'(a[22:0]);
    mb = 64'h80_0000 | 64'(b[22:0]);
    n = (ma << 38) / mb;
    r = (ma << 38) % mb;
    sh = n >= (64'd1 << 38) ? 15 : 14;
    e = ea - eb + (sh == 15 ? 127 : 126);
    mant = n >> sh;
    low = n & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (low > half || (low == half && (r != 0 || mant[0]))) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  // every cycle: any result shown must belong to a live operation and match the model
  always @(negedge clk)
    if (rstn) begin
      if (valid_out) begin
        chk("no_stale_result", {31'b0, pending}, 32'd1);
        if (pending) chk("res_vs_model", res, exp_res);
      end
      chk("ready_valid_exclusive", {31'b0, ready_in & valid_out}, 32'd0);
    end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit lit_en,
                       input logic [31:0] lit, input int lat_exp, input int hold);
    int lat, n;
    @(negedge clk);
    n = 0;
    while (!ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in_idle", {31'b0, ready_in}, 32'd1);
    x = a;
    y = b;
    valid_in = 1'b1;
    exp_res = model(a, b);
    pending = 1'b1;
    ready_out = hold == 0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    x = $urandom;
    y = $urandom;
    lat = 1;
    while (!valid_out && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    if (lit_en) chk("res_literal", res, lit);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid_out", {31'b0, valid_out}, 32'd1);
      chk("hold_ready_in", {31'b0, ready_in}, 32'd0);
      chk("hold_res", res, exp_res);
      valid_in = i == 4;
      if (i == 4) begin
        x = 32'h3F80_0000;
        y = 32'h4040_0000;
      end
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    pending = 1'b0;
    chk("after_handshake_valid_out", {31'b0, valid_out}, 32'd0);
    chk("after_handshake_ready_in", {31'b0, ready_in}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_in", {31'b0, ready_in}, 32'd1);
    chk("reset_valid_out", {31'b0, valid_out}, 32'd0);
    chk("reset_res", res, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    do_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 28, 0);
    do_op(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAB, 28, 0);
    do_op(32'h7F00_0000, 32'h3E80_0000, 1, 32'h7F80_0000, 28, 0);
    do_op(32'h0080_0000, 32'h4B00_0000, 1, 32'h0000_0000, 28, 0);
    do_op(32'hC0E0_0000, 32'h4000_0000, 1, 32'hC060_0000, 28, 0);
    do_op(32'hBF80_0000, 32'h0000_0000, 1, 32'hFF80_0000, SP_LAT, 0);
    do_op(32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, SP_LAT, 0);
    do_op(32'h8000_0000, 32'h4000_0000, 1, 32'h8000_0000, SP_LAT, 0);
    do_op(32'h7F80_0000, 32'hC000_0000, 1, 32'hFF80_0000, SP_LAT, 0);
    do_op(32'h4120_0000, 32'h40A0_0000, 1, 32'h4000_0000, 28, 10);
    for (int i = 0; i < 6; i++) begin
      ra = ($urandom & 32'h807F_FFFF) | (32'($urandom_range(100, 154)) << 23);
      rb = ($urandom & 32'h807F_FFFF) | (32'($urandom_range(100, 154)) << 23);
      do_op(ra, rb, 0, 32'h0, 28, 0);
    end
    @(negedge clk);
    x = 32'h40E0_0000;
    y = 32'h4000_0000;
    valid_in = 1'b1;
    exp_res = model(x, y);
    pending = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rstn = 1'b0;
    pending = 1'b0;
    #1;
    chk("midop_reset_ready_in", {31'b0, ready_in}, 32'd1);
    chk("midop_reset_valid_out", {31'b0, valid_out}, 32'd0);
    chk("midop_reset_res", res, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    chk("post_reset_idle_valid_out", {31'b0, valid_out}, 32'd0);
    chk("post_reset_idle_ready_in", {31'b0, ready_in}, 32'd1);
    do_op(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAB, 28, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port x, input, 32, IEEE-754 single dividend.
REQ-004 SHALL have port y, input, 32, IEEE-754 single divisor.
REQ-005 SHALL have port valid_in, input, 1, operands valid.
REQ-006 SHALL have port ready_in, output, 1, block can accept operands (high only in IDLE).
REQ-007 SHALL have port res, output, 32, quotient x/y.
REQ-008 SHALL have port valid_out, output, 1, res valid.
REQ-009 SHALL have port ready_out, input, 1, consumer accepts res.
REQ-010 SHALL have parameter ITER, default 26, number of quotient bits generated (fixed; other values unsupported).

Function
REQ-011 SHALL capture x and y into internal registers on the edge where valid_in & ready_in (acceptance); the caller may change the inputs afterwards.
REQ-012 SHALL implement the states IDLE -> DIV (ITER cycles) -> ROUND (1 cycle) -> DONE -> IDLE, with DONE -> IDLE on the edge where valid_out & ready_out.
REQ-013 SHALL assert valid_out only in DONE and hold res stable there until the handshake completes (back-pressure of any length).
REQ-014 SHALL give a fixed latency: valid_out first high 28 cycles after the acceptance edge when ready_out is held high.
REQ-015 SHALL accept no new operands in DIV, ROUND or DONE; valid_in is ignored there.
REQ-016 SHALL compute the sign as sx ^ sy.
REQ-017 SHALL divide the mantissas by restoring division, one bit per DIV cycle:
- inputs: {1,mx}, {1,my}
- quotient: q[25:0] = floor({1,mx}*2^25 / {1,my})
- remainder kept for sticky.
REQ-018 SHALL normalise the quotient:
- if q[25]=1: mantissa q[25:2], guard q[1], sticky q[0] | (rem != 0), exponent ex - ey + 127
- otherwise: mantissa q[24:1], guard q[0], sticky (rem != 0), exponent ex - ey + 126
- exponent is evaluated in 10-bit signed arithmetic.
REQ-019 SHALL round to nearest, ties to even:
- increment when guard & (sticky | lsb)
- on mantissa carry-out, clear the mantissa and increment the exponent.
REQ-020 SHALL produce {s,8'hFF,23'b0} when the final exponent is >= 255 (overflow).
REQ-021 SHALL produce {s,31'b0} when the final exponent is <= 0 (flush-to-zero underflow).
REQ-022 SHALL treat any operand with exponent 0 as signed zero (no subnormal support).
REQ-023 SHALL return {s,31'b0} for x zero, and {s,8'hFF,23'b0} for y zero or x=inf; x zero takes priority over y zero.
REQ-024 SHALL not special-case NaN inputs; inputs with exponent 255 other than x=inf give an unspecified result.
REQ-025 SHALL hold res at its previous value outside DONE.

Reset
REQ-026 SHALL, while rstn=0, force the state to IDLE, ready_in=1, valid_out=0, res=32'h0, and clear the iteration counter and datapath registers, regardless of the operation in progress.
REQ-027 SHALL, after release of rstn, accept operands on the first rising edge with valid_in=1; a result interrupted by reset is never emitted.

Configuration
REQ-028 SHALL support the macro FDIV_SEQ_EARLY_SPECIAL_EN:
- defined: zero or inf cases (REQ-023) go IDLE -> DONE directly, with valid_out first high 1 cycle after acceptance.
- undefined: every operation takes the full 28-cycle path, with the special result substituted in ROUND.

Verification
REQ-029 SHALL test x=0x40C00000, y=0x40000000, ready_out=1 -> res=0x40400000, valid_out first high 28 cycles after acceptance.
REQ-030 SHALL test x=0x3F800000, y=0x40400000 -> res=0x3EAAAAAB (round-up via sticky).
REQ-031 SHALL test x=0x7F000000, y=0x3E800000 -> res=0x7F800000; and x=0x00800000, y=0x4B000000 -> res=0x00000000.
REQ-032 SHALL test x=0xBF800000, y=0x00000000 -> res=0xFF800000, with latency 1 when FDIV_SEQ_EARLY_SPECIAL_EN is defined and 28 when undefined.
REQ-033 SHALL test holding ready_out=0 for 10 cycles in DONE -> valid_out and res stable, ready_in=0, and a valid_in pulse in that window ignored.
REQ-034 SHALL test rstn pulsed low at DIV cycle 10 -> ready_in=1 and valid_out=0 immediately, no stale result later, and the next operation correct.
